// File: rtl/memu_hs_pkg.sv
// Shared definitions for the memu_hs load/store unit: FSM states, funct3 decoding
// and address region decode.
package memu_hs_pkg;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_e;

  typedef enum logic [1:0] {REG_NONE, REG_MEM, REG_DEV} region_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 4'd1;
      2'b01:   return 4'd2;
      2'b10:   return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [7:0] byte_mask(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 8'h01;
      2'b01:   return 8'h03;
      2'b10:   return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  // Stores have no unsigned variants; loads have no 64-bit unsigned variant.
  function automatic logic f3_valid(input logic wen, input logic [2:0] funct3);
    return wen ? !funct3[2] : (funct3 != 3'b111);
  endfunction

  function automatic logic crosses(input logic [2:0] offset, input logic [2:0] funct3);
    return ({1'b0, offset} + size_bytes(funct3)) > 4'd8;
  endfunction

  function automatic region_e decode_region(input logic [63:0] addr,
                                            input logic [63:0] mem_base,
                                            input logic [63:0] mem_mask,
                                            input logic [63:0] dev_base,
                                            input logic [63:0] dev_mask);
    if ((addr & ~mem_mask) == mem_base)      return REG_MEM;
    else if ((addr & ~dev_mask) == dev_base) return REG_DEV;
    else                                     return REG_NONE;
  endfunction

endpackage

// File: rtl/memu_hs_lane.sv
// Byte-lane positioning and load extension over a two-beat (128-bit) window;
// the low 64 bits belong to beat 0 and the high 64 bits to beat 1.
module memu_lane
  import memu_hs_pkg::*;
(
  input  logic [2:0]   offset,
  input  logic [2:0]   funct3,
  input  logic [63:0]  wdata,
  input  logic [127:0] rdata,
  output logic [15:0]  wstrb,
  output logic [127:0] wdata_pos,
  output logic [63:0]  result
);

  logic [6:0]  shamt;
  logic [63:0] shifted;

  always_comb begin
    shamt     = {1'b0, offset, 3'b000};
    wstrb     = {8'h00, byte_mask(funct3)} << offset;
    wdata_pos = {64'h0, wdata} << shamt;
    shifted   = 64'(rdata >> shamt);
    case (funct3)
      F3_B:    result = {{56{shifted[7]}},  shifted[7:0]};
      F3_H:    result = {{48{shifted[15]}}, shifted[15:0]};
      F3_W:    result = {{32{shifted[31]}}, shifted[31:0]};
      F3_D:    result = shifted;
      F3_BU:   result = {56'h0, shifted[7:0]};
      F3_HU:   result = {48'h0, shifted[15:0]};
      F3_WU:   result = {32'h0, shifted[31:0]};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/memu_hs.sv
// Single-outstanding load/store unit routing requests to a memory or device port,
// splitting 8-byte-boundary crossings into two beats, with per-beat timeout.
module memu_hs
  import memu_hs_pkg::*;
#(
  parameter int          ADDR_W   = 64,
  parameter logic [63:0] MEM_BASE = 64'h8000_0000,
  parameter logic [63:0] MEM_MASK = 64'h0FFF_FFFF,
  parameter logic [63:0] DEV_BASE = 64'h2000_0000,
  parameter logic [63:0] DEV_MASK = 64'h0000_0FFF,
  parameter int          TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_wen,
  input  logic [2:0]        req_funct3,
  input  logic [63:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [63:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [7:0]        mem_wstrb,
  output logic [63:0]       mem_wdata,
  input  logic [63:0]       mem_rdata,
  output logic              dev_valid,
  input  logic              dev_ready,
  output logic [ADDR_W-1:0] dev_addr,
  output logic              dev_wen,
  output logic [7:0]        dev_wstrb,
  output logic [63:0]       dev_wdata,
  input  logic [63:0]       dev_rdata
);

  state_e            state, state_nxt;
  region_e           region_q, req_region;
  logic [ADDR_W-1:0] addr_q, beat_addr;
  logic              wen_q;
  logic [2:0]        funct3_q;
  logic [63:0]       wdata_q, beat0_q, rdata_q;
  logic              err_q;
  logic [15:0]       wait_cnt;
  logic              accept_ok, ds_valid, ds_ready, timed_out;
  logic [63:0]       ds_rdata;
  logic [15:0]       lane_wstrb;
  logic [127:0]      lane_wdata, lane_rdata;
  logic [63:0]       lane_result;

  memu_lane u_lane (
    .offset    (addr_q[2:0]),
    .funct3    (funct3_q),
    .wdata     (wdata_q),
    .rdata     (lane_rdata),
    .wstrb     (lane_wstrb),
    .wdata_pos (lane_wdata),
    .result    (lane_result)
  );

  // Device accesses that straddle a beat boundary are refused up front.
  always_comb begin
    req_region = decode_region(64'(req_addr), MEM_BASE, MEM_MASK, DEV_BASE, DEV_MASK);
    accept_ok  = f3_valid(req_wen, req_funct3) && (req_region != REG_NONE) &&
                 !((req_region == REG_DEV) && crosses(req_addr[2:0], req_funct3));
    ds_ready   = (region_q == REG_MEM) ? mem_ready : dev_ready;
    ds_rdata   = (region_q == REG_MEM) ? mem_rdata : dev_rdata;
    beat_addr  = {addr_q[ADDR_W-1:3], 3'b000} +
                 ((state == BEAT1) ? {{(ADDR_W-4){1'b0}}, 4'd8} : '0);
    lane_rdata = (state == BEAT1) ? {ds_rdata, beat0_q} : {64'h0, ds_rdata};
    timed_out  = !ds_ready && (wait_cnt == 16'(TIMEOUT - 1));
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    ds_valid   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = accept_ok ? BEAT0 : RESP;
      end
      BEAT0: begin
        ds_valid = 1'b1;
        if (ds_ready)       state_nxt = crosses(addr_q[2:0], funct3_q) ? BEAT1 : RESP;
        else if (timed_out) state_nxt = RESP;
      end
      BEAT1: begin
        ds_valid = 1'b1;
        if (ds_ready || timed_out) state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_valid = ds_valid && (region_q == REG_MEM);
    dev_valid = ds_valid && (region_q == REG_DEV);
    mem_addr  = beat_addr;
    dev_addr  = beat_addr;
    mem_wen   = wen_q;
    dev_wen   = wen_q;
    mem_wstrb = (state == BEAT1) ? lane_wstrb[15:8]   : lane_wstrb[7:0];
    mem_wdata = (state == BEAT1) ? lane_wdata[127:64] : lane_wdata[63:0];
    dev_wstrb = mem_wstrb;
    dev_wdata = mem_wdata;
    resp_rdata = rdata_q;
    resp_err   = err_q;
  end

  // Response data is written only on the final successful beat, so stores,
  // refused requests and timeouts all return zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      region_q <= REG_NONE;
      addr_q   <= '0;
      wen_q    <= 1'b0;
      funct3_q <= '0;
      wdata_q  <= '0;
      beat0_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (req_valid) begin
          region_q <= req_region;
          addr_q   <= req_addr;
          wen_q    <= req_wen;
          funct3_q <= req_funct3;
          wdata_q  <= req_wdata;
          beat0_q  <= '0;
          rdata_q  <= '0;
          err_q    <= !accept_ok;
          wait_cnt <= '0;
        end
        BEAT0, BEAT1: begin
          if (ds_ready) begin
            wait_cnt <= '0;
            if (state == BEAT0) beat0_q <= ds_rdata;
            if (state_nxt == RESP) rdata_q <= wen_q ? 64'h0 : lane_result;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
            if (timed_out) err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
